// File: rtl/bsg_locking_packet_mux_pkg.sv
// bsg_locking_packet_mux_pkg: state encoding shared by the locking packet mux
package bsg_locking_packet_mux_pkg;
  typedef enum logic {IDLE, LOCKED} state_e;
endpackage

// File: rtl/bsg_arb_fixed.sv
// bsg_arb_fixed: fixed-priority one-hot grant, direction chosen by lo_to_hi_p
module bsg_arb_fixed #(
  parameter int inputs_p = 2,
  parameter int lo_to_hi_p = 0
) (
  input  logic                ready_i,
  input  logic [inputs_p-1:0] reqs_i,
  output logic [inputs_p-1:0] grants_o
);
  logic [inputs_p-1:0] req_s, gnt_s;
  for (genvar i = 0; i < inputs_p; i++) begin : g_rev
    assign req_s[i] = reqs_i[lo_to_hi_p ? i : inputs_p-1-i];
    assign grants_o[lo_to_hi_p ? i : inputs_p-1-i] = gnt_s[i];
  end
  assign gnt_s = req_s & (~req_s + inputs_p'(1)) & {inputs_p{ready_i}};
endmodule

// File: rtl/bsg_encode_one_hot.sv
// bsg_encode_one_hot: one-hot vector to binary index plus any-valid
module bsg_encode_one_hot #(
  parameter int width_p = 2,
  parameter int lg_width_p = width_p == 1 ? 1 : $clog2(width_p)
) (
  input  logic [width_p-1:0]    i,
  output logic [lg_width_p-1:0] addr_o,
  output logic                  v_o
);
  always_comb begin
    addr_o = '0;
    for (int k = 0; k < width_p; k++)
      addr_o = addr_o | (i[k] ? lg_width_p'(k) : '0);
  end
  assign v_o = |i;
endmodule

// File: rtl/bsg_mux_one_hot.sv
// bsg_mux_one_hot: AND-OR word mux driven by a one-hot select
module bsg_mux_one_hot #(
  parameter int width_p = 8,
  parameter int els_p = 2
) (
  input  logic [els_p-1:0][width_p-1:0] data_i,
  input  logic [els_p-1:0]              sel_one_hot_i,
  output logic [width_p-1:0]            data_o
);
  always_comb begin
    data_o = '0;
    for (int k = 0; k < els_p; k++)
      data_o = data_o | (data_i[k] & {width_p{sel_one_hot_i[k]}});
  end
endmodule

// File: rtl/bsg_locking_packet_mux.sv
// bsg_locking_packet_mux: fixed-priority packet mux that locks onto a source until its length-counted tail transfers
module bsg_locking_packet_mux
  import bsg_locking_packet_mux_pkg::*;
#(
  parameter int inputs_p = 2,
  parameter int width_p = 8,
  parameter int len_width_p = 4,
  parameter int lo_to_hi_p = 0,
  localparam int sel_w_lp = inputs_p == 1 ? 1 : $clog2(inputs_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [inputs_p-1:0]               v_i,
  input  logic [inputs_p-1:0][width_p-1:0]  data_i,
  output logic [inputs_p-1:0]               yumi_o,
  output logic                              v_o,
  output logic [width_p-1:0]                data_o,
  input  logic                              ready_i,
  output logic                              locked_o,
  output logic [sel_w_lp-1:0]               sel_id_o
);
  state_e state_r, state_n;
  logic [sel_w_lp-1:0] sel_r, sel_n, pick_id;
  logic [len_width_p-1:0] cnt_r, cnt_n, hdr_len;
  logic [inputs_p-1:0] grants, sel_oh;
  logic pick_v, locked, xfer;
  bsg_arb_fixed #(.inputs_p(inputs_p), .lo_to_hi_p(lo_to_hi_p)) arb (
    .ready_i(1'b1),
    .reqs_i(v_i),
    .grants_o(grants)
  );
  bsg_encode_one_hot #(.width_p(inputs_p), .lg_width_p(sel_w_lp)) enc (
    .i(grants),
    .addr_o(pick_id),
    .v_o(pick_v)
  );
  bsg_mux_one_hot #(.width_p(width_p), .els_p(inputs_p)) mux (
    .data_i(data_i),
    .sel_one_hot_i(sel_oh),
    .data_o(data_o)
  );
  assign hdr_len = data_o[len_width_p-1:0];
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_r <= IDLE;
      sel_r <= '0;
      cnt_r <= '0;
    end else begin
      state_r <= state_n;
      sel_r <= sel_n;
      cnt_r <= cnt_n;
    end
  always_comb begin
    state_n = ~xfer ? state_r : state_r == IDLE ? (hdr_len != '0 ? LOCKED : IDLE) : (cnt_r == len_width_p'(1) ? IDLE : LOCKED);
    sel_n = xfer & (state_r == IDLE) ? pick_id : sel_r;
    cnt_n = ~xfer ? cnt_r : state_r == IDLE ? hdr_len : cnt_r - len_width_p'(1);
  end
  always_comb begin
    locked = state_r == LOCKED;
    sel_id_o = locked ? sel_r : pick_id;
    sel_oh = locked ? inputs_p'(1) << sel_r : grants;
    v_o = ~reset_i & (locked ? |(v_i & sel_oh) : pick_v);
    locked_o = ~reset_i & locked;
    xfer = v_o & ready_i;
    yumi_o = sel_oh & {inputs_p{xfer}};
  end
endmodule
